arb_rr2: RTL and testbench

ARB_RR2 -- requirements
Module: arb_rr2

---
 rtl/arb_pkg.sv | 28 ++
 rtl/arb_rr2_if.sv | 34 +++
 rtl/arb_hold_timer.sv | 42 ++++
 rtl/arb_rr2.sv | 105 ++++++++++
 tb/tb_arb_rr2.sv | 241 ++++++++++++++++++++++++
 5 files changed

// File: rtl/arb_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | arb_pkg : shared state/grant encodings for arb_rr2            rev 1.0    |
// +--------------------------------------------------------------------------+
package arb_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      GNT0 = 2'd1,
      GNT1 = 2'd2
   } arb_state_e;

   localparam logic [1:0] GNT_NONE = 2'b00;
   localparam logic [1:0] GNT_0    = 2'b01;
   localparam logic [1:0] GNT_1    = 2'b10;

   localparam int MAX_HOLD_DEFAULT = 8;

   function automatic logic [1:0] state_grant(arb_state_e s);
      case (s)
         GNT0:    return GNT_0;
         GNT1:    return GNT_1;
         default: return GNT_NONE;
      endcase
   endfunction

endpackage
`default_nettype wire

// File: rtl/arb_rr2_if.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | arb_rr2_if : two-requester request/grant bus with clock and reset  rev 1.0 |
// +--------------------------------------------------------------------------+
interface arb_rr2_if (
   input logic clk,
   input logic rst
);

   logic [1:0] request;
   logic [1:0] grant;
   logic       preempt;
   logic       busy;

   modport master (
      input  clk,
      input  rst,
      input  grant,
      input  preempt,
      input  busy,
      output request
   );

   modport slave (
      input  clk,
      input  rst,
      input  request,
      output grant,
      output preempt,
      output busy
   );

endinterface
`default_nettype wire

// File: rtl/arb_hold_timer.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | arb_hold_timer : saturating hold counter, expired at MAX_HOLD-1  rev 1.0  |
// +--------------------------------------------------------------------------+
module arb_hold_timer #(
   parameter int MAX_HOLD = 8
) (
   input  logic clk,
   input  logic rst,
   input  logic clear,
   input  logic enable,
   output logic expired
);

   localparam int            CW   = $clog2(MAX_HOLD);
   localparam logic [CW-1:0] LAST = CW'(MAX_HOLD - 1);

   logic [CW-1:0] cnt_q;
   logic [CW-1:0] cnt_d;

   // Clear wins over enable so a fresh owner always starts from zero.
   always_comb begin
      cnt_d = cnt_q;
      if (clear) begin
         cnt_d = '0;
      end else if (enable && (cnt_q != LAST)) begin
         cnt_d = cnt_q + CW'(1);
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   assign expired = (cnt_q == LAST);

endmodule
`default_nettype wire

// File: rtl/arb_rr2.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | arb_rr2 : two-way round-robin arbiter with hold-timeout preemption rev 1.0|
// +--------------------------------------------------------------------------+
module arb_rr2
   import arb_pkg::*;
#(
   parameter int MAX_HOLD = MAX_HOLD_DEFAULT
) (
   arb_rr2_if.slave bus
);

   logic       clk;
   logic       rst_n;
   logic [1:0] req;

   assign clk   = bus.clk;
   assign rst_n = bus.rst;
   assign req   = bus.request;

   arb_state_e state_q;
   arb_state_e state_d;
   logic       last_owner_q;
   logic       last_owner_d;
   logic       preempt_q;
   logic       preempt_d;
   logic       hold_expired;
   logic       hold_clear;
   logic       hold_enable;
   logic [1:0] grant;

   always_comb begin
      state_d   = state_q;
      preempt_d = 1'b0;
      case (state_q)
         IDLE: begin
            case (req)
               2'b01:   state_d = GNT0;
               2'b10:   state_d = GNT1;
               2'b11:   state_d = last_owner_q ? GNT0 : GNT1;
               default: state_d = IDLE;
            endcase
         end
         GNT0: begin
            if (!req[0]) begin
               state_d = req[1] ? GNT1 : IDLE;
            end else if (req[1] && hold_expired) begin
               state_d   = GNT1;
               preempt_d = 1'b1;
            end
         end
         GNT1: begin
            if (!req[1]) begin
               state_d = req[0] ? GNT0 : IDLE;
            end else if (req[0] && hold_expired) begin
               state_d   = GNT0;
               preempt_d = 1'b1;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_comb begin
      last_owner_d = last_owner_q;
      if ((state_d == GNT0) && (state_q != GNT0)) begin
         last_owner_d = 1'b0;
      end else if ((state_d == GNT1) && (state_q != GNT1)) begin
         last_owner_d = 1'b1;
      end
   end

   // last_owner resets to 1 so requester 0 wins the first tie.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q      <= IDLE;
         last_owner_q <= 1'b1;
         preempt_q    <= 1'b0;
      end else begin
         state_q      <= state_d;
         last_owner_q <= last_owner_d;
         preempt_q    <= preempt_d;
      end
   end

   assign hold_clear  = (state_d != state_q) && (state_d != IDLE);
   assign hold_enable = (state_q != IDLE);

   arb_hold_timer #(
      .MAX_HOLD (MAX_HOLD)
   ) u_hold_timer (
      .clk     (clk),
      .rst     (rst_n),
      .clear   (hold_clear),
      .enable  (hold_enable),
      .expired (hold_expired)
   );

   assign grant       = state_grant(state_q);
   assign bus.grant   = grant;
   assign bus.preempt = preempt_q;
   assign bus.busy    = (grant != GNT_NONE);

endmodule
`default_nettype wire

// File: tb/tb_arb_rr2.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_arb_rr2 : scoreboard bench for arb_rr2 with MAX_HOLD = 4       rev 1.0 |
// +--------------------------------------------------------------------------+
module tb_arb_rr2;
   import arb_pkg::*;

   localparam int HOLD = 4;

   typedef struct packed {
      logic [1:0] g;
      logic       p;
   } exp_t;

   logic clk   = 1'b0;
   logic rst_n = 1'b1;
   int   total = 0;
   int   bad   = 0;
   exp_t exp_q[$];

   always #5 clk = ~clk;

   arb_rr2_if bus (.clk(clk), .rst(rst_n));

   arb_rr2 #(.MAX_HOLD(HOLD)) dut (.bus(bus));

   // Concurrent checks: grant one-hot/zero, request known, no grant without prior request.
   logic [1:0] req_seen   = 2'b00;
   logic       seen_valid = 1'b0;

   always @(posedge clk) begin
      req_seen   <= bus.request;
      seen_valid <= rst_n;
   end

   always @(negedge clk) begin
      if (rst_n) begin
         total++;
         if ((bus.grant === 2'b11) || $isunknown(bus.request)) begin
            bad++;
            $display("FAIL monitor_onehot: grant=%b request=%b, need grant!=11 and known request",
                     bus.grant, bus.request);
         end
         if (seen_valid) begin
            total++;
            if ((bus.grant & ~req_seen) !== 2'b00) begin
               bad++;
               $display("FAIL monitor_no_request: grant=%b after sampled request=%b",
                        bus.grant, req_seen);
            end
         end
      end
   end

   task automatic apply_reset();
      @(posedge clk);
      #1;
      bus.request = 2'b00;
      rst_n       = 1'b0;
      @(posedge clk);
      #1;
      rst_n = 1'b1;
   endtask

   task automatic test_reset();
      exp_t e;
      bus.request = 2'b11;
      #2 rst_n = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      total++;
      if ({bus.grant, bus.preempt, bus.busy} !== 4'b0000) begin
         bad++;
         $display("FAIL reset_hold: grant=%b preempt=%b busy=%b, want 00/0/0",
                  bus.grant, bus.preempt, bus.busy);
      end
      bus.request = 2'b00;
      rst_n       = 1'b1;
      exp_q.push_back('{g: GNT_NONE, p: 1'b0});
      @(posedge clk);
      #1;
      e = exp_q.pop_front();
      total++;
      if ((bus.grant !== e.g) || (bus.preempt !== e.p) || (bus.busy !== (e.g != 2'b00))) begin
         bad++;
         $display("FAIL reset_release: grant=%b preempt=%b busy=%b, want grant=%b preempt=%b",
                  bus.grant, bus.preempt, bus.busy, e.g, e.p);
      end
   endtask

   task automatic test_single();
      logic [1:0] rq [3] = '{2'b01, 2'b01, 2'b00};
      logic [1:0] eg [3] = '{2'b01, 2'b01, 2'b00};
      exp_t e;
      apply_reset();
      for (int k = 0; k < 3; k++) begin
         bus.request = rq[k];
         exp_q.push_back('{g: eg[k], p: 1'b0});
         @(posedge clk);
         #1;
         e = exp_q.pop_front();
         total++;
         if ((bus.grant !== e.g) || (bus.preempt !== e.p) || (bus.busy !== (e.g != 2'b00))) begin
            bad++;
            $display("FAIL single[%0d]: grant=%b preempt=%b busy=%b, want grant=%b preempt=%b",
                     k, bus.grant, bus.preempt, bus.busy, e.g, e.p);
         end
      end
   endtask

   task automatic test_tie_handoff();
      logic [1:0] rq [7] = '{2'b11, 2'b10, 2'b00, 2'b11, 2'b00, 2'b11, 2'b00};
      logic [1:0] eg [7] = '{2'b01, 2'b10, 2'b00, 2'b01, 2'b00, 2'b10, 2'b00};
      exp_t e;
      apply_reset();
      for (int k = 0; k < 7; k++) begin
         bus.request = rq[k];
         exp_q.push_back('{g: eg[k], p: 1'b0});
         @(posedge clk);
         #1;
         e = exp_q.pop_front();
         total++;
         if ((bus.grant !== e.g) || (bus.preempt !== e.p) || (bus.busy !== (e.g != 2'b00))) begin
            bad++;
            $display("FAIL tie_handoff[%0d]: grant=%b preempt=%b busy=%b, want grant=%b preempt=%b",
                     k, bus.grant, bus.preempt, bus.busy, e.g, e.p);
         end
      end
   endtask

   task automatic test_timeout();
      exp_t e;
      apply_reset();
      for (int k = 0; k < 10; k++) begin
         if (k < 9) begin
            bus.request = 2'b11;
            exp_q.push_back('{g: (k < HOLD) ? 2'b01 : ((k < 2 * HOLD) ? 2'b10 : 2'b01),
                              p: (k == HOLD) || (k == 2 * HOLD)});
         end else begin
            bus.request = 2'b00;
            exp_q.push_back('{g: 2'b00, p: 1'b0});
         end
         @(posedge clk);
         #1;
         e = exp_q.pop_front();
         total++;
         if ((bus.grant !== e.g) || (bus.preempt !== e.p) || (bus.busy !== (e.g != 2'b00))) begin
            bad++;
            $display("FAIL timeout[%0d]: grant=%b preempt=%b busy=%b, want grant=%b preempt=%b",
                     k, bus.grant, bus.preempt, bus.busy, e.g, e.p);
         end
      end
   endtask

   task automatic test_hold_solo();
      exp_t e;
      apply_reset();
      for (int k = 0; k < 22; k++) begin
         if (k < 20) begin
            bus.request = 2'b01;
            exp_q.push_back('{g: 2'b01, p: 1'b0});
         end else if (k == 20) begin
            bus.request = 2'b11;
            exp_q.push_back('{g: 2'b10, p: 1'b1});
         end else begin
            bus.request = 2'b00;
            exp_q.push_back('{g: 2'b00, p: 1'b0});
         end
         @(posedge clk);
         #1;
         e = exp_q.pop_front();
         total++;
         if ((bus.grant !== e.g) || (bus.preempt !== e.p) || (bus.busy !== (e.g != 2'b00))) begin
            bad++;
            $display("FAIL hold_solo[%0d]: grant=%b preempt=%b busy=%b, want grant=%b preempt=%b",
                     k, bus.grant, bus.preempt, bus.busy, e.g, e.p);
         end
      end
   endtask

   task automatic test_async_reset();
      logic [1:0] rq [7] = '{2'b10, 2'b10, 2'b11, 2'b01, 2'b10, 2'b01, 2'b00};
      logic [1:0] eg [7] = '{2'b10, 2'b10, 2'b01, 2'b01, 2'b10, 2'b01, 2'b00};
      exp_t e;
      apply_reset();
      for (int k = 0; k < 7; k++) begin
         if (k == 2) begin
            #2 rst_n = 1'b0;
            #1;
            total++;
            if ({bus.grant, bus.preempt, bus.busy} !== 4'b0000) begin
               bad++;
               $display("FAIL async_drop: grant=%b preempt=%b busy=%b, want 00/0/0 before edge",
                        bus.grant, bus.preempt, bus.busy);
            end
            bus.request = 2'b11;
            @(posedge clk);
            #1;
            total++;
            if (bus.grant !== 2'b00) begin
               bad++;
               $display("FAIL async_held: grant=%b, want 00 while in reset", bus.grant);
            end
            rst_n = 1'b1;
         end
         bus.request = rq[k];
         exp_q.push_back('{g: eg[k], p: 1'b0});
         @(posedge clk);
         #1;
         e = exp_q.pop_front();
         total++;
         if ((bus.grant !== e.g) || (bus.preempt !== e.p) || (bus.busy !== (e.g != 2'b00))) begin
            bad++;
            $display("FAIL async_reset[%0d]: grant=%b preempt=%b busy=%b, want grant=%b preempt=%b",
                     k, bus.grant, bus.preempt, bus.busy, e.g, e.p);
         end
      end
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      bus.request = 2'b00;
      test_reset();
      test_single();
      test_tie_handoff();
      test_timeout();
      test_hold_solo();
      test_async_reset();
      @(posedge clk);
      #1;
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
`default_nettype wire
